led_chase_decoder: RTL

Monitors the one-hot running-light pattern driven onto the LED bus and decodes it back to position, direction and lap count. Flags malformed patterns, skipped steps and, optionally, a stalled pattern. It sits on the receiving side of the LED chase generator, in the same clock domain as the board logic, and is used for self-check and readback. The LED bus is updated from a divided counter clock, so the block synchronises it before use.

---
 rtl/led_chase_decoder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/led_chase_decoder.sv
// Decodes a one-hot LED chase pattern back into position, direction and lap count.
// Optional stall detection is enabled by defining LED_CHASE_DECODER_STALL_EN.
module led_chase_decoder #(
    parameter int WIDTH        = 8,
    parameter int LAP_WIDTH    = 16,
    parameter int STALL_CYCLES = 1000000,
    localparam int POS_W       = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     led,
    input  logic                 clear_err,
    output logic [POS_W-1:0]     pos,
    output logic                 pos_valid,
    output logic                 dir,
    output logic                 step,
    output logic [LAP_WIDTH-1:0] lap_count,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] FAULT  = 2'd2;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_ONEHOT = 2'd1;
    localparam logic [1:0] ERR_SKIP   = 2'd2;
    localparam logic [1:0] ERR_STALL  = 2'd3;

    if (WIDTH < 3 || STALL_CYCLES < 1) begin : g_bad_param
        $error("led_chase_decoder: WIDTH must be >= 3 and STALL_CYCLES >= 1");
    end

    logic [WIDTH-1:0]     sync1_q, sync2_q, prev_q;
    logic [1:0]           state_q, state_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 pos_valid_q, pos_valid_d;
    logic                 dir_q, dir_d;
    logic                 step_q, step_d;
    logic [LAP_WIDTH-1:0] lap_q, lap_d;
    logic                 err_q, err_d;
    logic [1:0]           err_code_q, err_code_d;

    logic                 change;
    logic                 s_onehot;
    logic [POS_W-1:0]     s_idx;
    logic [POS_W-1:0]     up_idx, dn_idx;

`ifdef LED_CHASE_DECODER_STALL_EN
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
`endif

    // sync2_q is the synchronised pattern; prev_q is its value one cycle earlier.
    assign change   = (sync2_q != prev_q);
    assign s_onehot = (sync2_q != '0) && ((sync2_q & (sync2_q - WIDTH'(1))) == '0);
    assign up_idx   = (pos_q == POS_W'(WIDTH - 1)) ? '0 : pos_q + POS_W'(1);
    assign dn_idx   = (pos_q == '0) ? POS_W'(WIDTH - 1) : pos_q - POS_W'(1);

    always_comb begin
        s_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i]) s_idx = POS_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        pos_valid_d = pos_valid_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        lap_d       = lap_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
`ifdef LED_CHASE_DECODER_STALL_EN
        stall_cnt_d = stall_cnt_q;
`endif
        case (state_q)
            SEARCH: begin
                if (s_onehot) begin
                    state_d     = TRACK;
                    pos_d       = s_idx;
                    pos_valid_d = 1'b1;
`ifdef LED_CHASE_DECODER_STALL_EN
                    stall_cnt_d = '0;
`endif
                end
            end
            TRACK: begin
                if (change) begin
`ifdef LED_CHASE_DECODER_STALL_EN
                    stall_cnt_d = '0;
`endif
                    if (!s_onehot) begin
                        state_d     = FAULT;
                        err_d       = 1'b1;
                        pos_valid_d = 1'b0;
                        err_code_d  = ERR_ONEHOT;
                    end else if (s_idx == up_idx) begin
                        dir_d  = 1'b1;
                        step_d = 1'b1;
                        pos_d  = s_idx;
                        if (pos_q == POS_W'(WIDTH - 1)) lap_d = lap_q + LAP_WIDTH'(1);
                    end else if (s_idx == dn_idx) begin
                        dir_d  = 1'b0;
                        step_d = 1'b1;
                        pos_d  = s_idx;
                        if (pos_q == '0) lap_d = lap_q + LAP_WIDTH'(1);
                    end else begin
                        state_d     = FAULT;
                        err_d       = 1'b1;
                        pos_valid_d = 1'b0;
                        err_code_d  = ERR_SKIP;
                    end
                end else begin
`ifdef LED_CHASE_DECODER_STALL_EN
                    // Fault fires on the cycle the idle count reaches STALL_CYCLES.
                    if (stall_cnt_q == STALL_W'(STALL_CYCLES - 1)) begin
                        state_d     = FAULT;
                        err_d       = 1'b1;
                        pos_valid_d = 1'b0;
                        err_code_d  = ERR_STALL;
                    end else begin
                        stall_cnt_d = stall_cnt_q + STALL_W'(1);
                    end
`endif
                end
            end
            FAULT: begin
                if (clear_err) begin
                    state_d    = SEARCH;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            state_q     <= SEARCH;
            pos_q       <= '0;
            pos_valid_q <= 1'b0;
            dir_q       <= 1'b1;
            step_q      <= 1'b0;
            lap_q       <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            sync1_q     <= led;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            lap_q       <= lap_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

`ifdef LED_CHASE_DECODER_STALL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end
`endif

    assign pos       = pos_q;
    assign pos_valid = pos_valid_q;
    assign dir       = dir_q;
    assign step      = step_q;
    assign lap_count = lap_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign state_dbg = state_q;

endmodule
